router_bypass_ctrl: RTL

- Sequencer that decides when a VC router is switched between normal operation and registered bypass, with the router clock gated while in bypass.
- Tracks per-port, per-VC input-buffer occupancy from flit arrivals and returned credit grants.
- Enters bypass only once the router is empty and quiet, and leaves bypass only once the one-deep bypass register path is quiet.
- Drives the bypass select and clock-enable control of the router bypass wrapper; sits beside the wrapper in each tile.

---
 rtl/router_ctrl_pkg.sv | 27 ++
 rtl/vc_occ_counter.sv | 43 ++++
 rtl/router_bypass_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/router_ctrl_pkg.sv
// Shared types and defaults for the router bypass controller and its
// per-VC occupancy counters.
package router_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    DRAIN     = 3'd1,
    ENTER     = 3'd2,
    BYPASS    = 3'd3,
    EXIT_WAIT = 3'd4,
    LEAVE     = 3'd5
  } ctrlState_e;

  localparam int DEF_NUM_PORTS     = 5;
  localparam int DEF_NUM_VCS       = 2;
  localparam int DEF_VC_W          = 1;
  localparam int DEF_BUF_DEPTH     = 4;
  localparam int DEF_QUIET_CYCLES  = 8;
  localparam int DEF_SETTLE_CYCLES = 2;
  localparam int DEF_DRAIN_TIMEOUT = 1024;

  // Bits needed to count 0..depth inclusive.
  function automatic int occWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vc_occ_counter.sv
// Saturating up/down occupancy counter for one (port, VC) input buffer.
// err flags an attempted underflow or overflow in the current cycle.
module vc_occ_counter
  import router_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_BUF_DEPTH,
  parameter int W     = occWidth(DEF_BUF_DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         err
);

  logic atFull;
  logic atEmpty;

  assign atFull  = (count == W'(DEPTH));
  assign atEmpty = (count == '0);

  always_comb begin
    err = 1'b0;
    if (inc && !dec && atFull) err = 1'b1;
    if (dec && !inc && atEmpty) err = 1'b1;
  end

  // A simultaneous increment and decrement cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !dec && !atFull) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !atEmpty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/router_bypass_ctrl.sv
// Sequences a VC router between normal operation and registered bypass,
// entering only when the buffers are empty and the inputs have been quiet.
module router_bypass_ctrl
  import router_ctrl_pkg::*;
#(
  parameter int NUM_PORTS     = DEF_NUM_PORTS,
  parameter int NUM_VCS       = DEF_NUM_VCS,
  parameter int VC_W          = DEF_VC_W,
  parameter int BUF_DEPTH     = DEF_BUF_DEPTH,
  parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_bypass,
  input  logic [NUM_PORTS-1:0]         in_flit_valid,
  input  logic [NUM_PORTS*VC_W-1:0]    in_flit_vc,
  input  logic [NUM_PORTS*NUM_VCS-1:0] in_credit_grant,
  output logic                         bypass_o,
  output logic                         bypass_ack,
  output logic                         drain_abort,
  output logic                         occ_err,
  output logic [2:0]                   state_o
);

  localparam int OCC_W = occWidth(BUF_DEPTH);
  localparam int QW    = $clog2(QUIET_CYCLES + 1);
  localparam int SW    = $clog2(SETTLE_CYCLES + 1);
  localparam int TW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam int NCNT  = NUM_PORTS * NUM_VCS;

  ctrlState_e    state;
  logic [QW-1:0] quietCnt;
  logic [SW-1:0] settleCnt;
  logic [TW-1:0] drainCnt;
  logic [NCNT-1:0] cntZero;
  logic [NCNT-1:0] cntErr;
  logic empty;
  logic idle;
  logic clearOcc;

  // Counters are frozen whenever the router is bypassed, and wiped in
  // EXIT_WAIT so the router restarts from a clean slate.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
    for (genvar v = 0; v < NUM_VCS; v++) begin : gVc
      logic             incOcc;
      logic             decOcc;
      logic [OCC_W-1:0] occCount;

      assign incOcc = in_flit_valid[p] && (in_flit_vc[p*VC_W +: VC_W] == VC_W'(v)) && !bypass_o;
      assign decOcc = in_credit_grant[p*NUM_VCS + v] && !bypass_o;
      assign cntZero[p*NUM_VCS + v] = (occCount == '0);

      vc_occ_counter #(.DEPTH(BUF_DEPTH), .W(OCC_W)) uOcc (
        .clk   (clk),
        .reset (reset),
        .clear (clearOcc),
        .inc   (incOcc),
        .dec   (decOcc),
        .count (occCount),
        .err   (cntErr[p*NUM_VCS + v])
      );
    end
  end

  assign empty    = &cntZero;
  assign idle     = ~|in_flit_valid;
  assign clearOcc = (state == EXIT_WAIT);
  assign state_o  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_err <= 1'b0;
    else if (|cntErr) occ_err <= 1'b1;
  end

  // DRAIN checks the registered quiet count, giving 1 + QUIET_CYCLES latency;
  // EXIT_WAIT leaves on the QUIET_CYCLES-th consecutive idle cycle itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      quietCnt    <= '0;
      settleCnt   <= '0;
      drainCnt    <= '0;
      bypass_o    <= 1'b0;
      bypass_ack  <= 1'b0;
      drain_abort <= 1'b0;
    end else begin
      drain_abort <= 1'b0;
      unique case (state)
        RUN: begin
          bypass_o   <= 1'b0;
          bypass_ack <= 1'b0;
          if (req_bypass) begin
            state    <= DRAIN;
            quietCnt <= '0;
            drainCnt <= '0;
          end
        end
        DRAIN: begin
          if (!req_bypass) begin
            state <= RUN;
          end else if (quietCnt == QW'(QUIET_CYCLES)) begin
            state     <= ENTER;
            bypass_o  <= 1'b1;
            settleCnt <= '0;
          end else if (drainCnt == TW'(DRAIN_TIMEOUT - 1)) begin
            state       <= RUN;
            drain_abort <= 1'b1;
          end else begin
            drainCnt <= drainCnt + 1'b1;
            if (empty && idle) quietCnt <= quietCnt + 1'b1;
            else quietCnt <= '0;
          end
        end
        ENTER: begin
          if (settleCnt == SW'(SETTLE_CYCLES - 1)) begin
            state      <= BYPASS;
            bypass_ack <= 1'b1;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
        BYPASS: begin
          if (!req_bypass) begin
            state    <= EXIT_WAIT;
            quietCnt <= '0;
          end
        end
        EXIT_WAIT: begin
          if (req_bypass) begin
            state <= BYPASS;
          end else if (idle && quietCnt == QW'(QUIET_CYCLES - 1)) begin
            state     <= LEAVE;
            bypass_o  <= 1'b0;
            settleCnt <= '0;
          end else if (idle) begin
            quietCnt <= quietCnt + 1'b1;
          end else begin
            quietCnt <= '0;
          end
        end
        LEAVE: begin
          if (settleCnt == SW'(SETTLE_CYCLES - 1)) begin
            state      <= RUN;
            bypass_ack <= 1'b0;
          end else begin
            settleCnt <= settleCnt + 1'b1;
          end
        end
        default: begin
          state      <= RUN;
          bypass_o   <= 1'b0;
          bypass_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule
